// File: rtl/seq_red_or.sv
// Multi-beat OR-reduction stage: folds a frame of `beats` words into a single
// registered OR bit plus the index of the first non-zero beat.
module seq_red_or #(
  parameter  int unsigned width = 8,
  parameter  int unsigned beats = 4,
  localparam int unsigned iw    = (beats > 1) ? $clog2(beats) : 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Flush,
  input  logic             AValid,
  output logic             AReady,
  input  logic [width-1:0] A,
  output logic             ZValid,
  input  logic             ZReady,
  output logic             Z,
  output logic [iw-1:0]    FirstIdx
);

  localparam logic [iw-1:0] last_beat = iw'(beats - 1);

  logic [iw-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          fnd_q, fnd_d;
  logic [iw-1:0] idx_q, idx_d;
  logic          zvalid_q, zvalid_d;
  logic          z_q, z_d;
  logic [iw-1:0] first_idx_q, first_idx_d;

  logic any_bit;
  logic is_last;
  logic accept;

  assign any_bit = |A;
  assign is_last = (cnt_q == last_beat);
  // Only a last beat can stall, and only while the held result is unconsumed.
  assign AReady  = !(is_last && zvalid_q && !ZReady);
  assign accept  = AValid && AReady;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    fnd_d       = fnd_q;
    idx_d       = idx_q;
    zvalid_d    = zvalid_q;
    z_d         = z_q;
    first_idx_d = first_idx_q;

    if (zvalid_q && ZReady) zvalid_d = 1'b0;

    if (accept) begin
      if (is_last) begin
        cnt_d = '0;
        acc_d = 1'b0;
        fnd_d = 1'b0;
        idx_d = '0;
        if (!Flush) begin
          // A same-cycle reload keeps ZValid high across a consume.
          zvalid_d    = 1'b1;
          z_d         = acc_q | any_bit;
          first_idx_d = fnd_q ? idx_q : (any_bit ? last_beat : '0);
        end
      end else begin
        cnt_d = cnt_q + iw'(1);
        acc_d = acc_q | any_bit;
        if (!fnd_q && any_bit) begin
          fnd_d = 1'b1;
          idx_d = cnt_q;
        end
      end
    end

    // Flush drops the partial frame (and any beat accepted with it) but leaves
    // the output register and its handshake alone.
    if (Flush) begin
      cnt_d = '0;
      acc_d = 1'b0;
      fnd_d = 1'b0;
      idx_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      fnd_q       <= 1'b0;
      idx_q       <= '0;
      zvalid_q    <= 1'b0;
      z_q         <= 1'b0;
      first_idx_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      fnd_q       <= fnd_d;
      idx_q       <= idx_d;
      zvalid_q    <= zvalid_d;
      z_q         <= z_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign ZValid   = zvalid_q;
  assign Z        = z_q;
  assign FirstIdx = first_idx_q;

endmodule

// File: tb/tb_seq_red_or.sv
// Directed bench for seq_red_or: a beats=4 instance for the main scenarios and
// a beats=1 instance for single-beat frames.
module tb_seq_red_or;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a;
  logic       z_valid;
  logic       z_ready;
  logic       z;
  logic [1:0] first_idx;

  logic       a_valid1;
  logic       a_ready1;
  logic [7:0] a1;
  logic       z_valid1;
  logic       z_ready1;
  logic       z1;
  logic [0:0] first_idx1;

  int n_vec  = 0;
  int n_miss = 0;

  seq_red_or #(.width(8), .beats(4)) dut (
    .CLK(clk), .RSTn(rst_n), .Flush(flush),
    .AValid(a_valid), .AReady(a_ready), .A(a),
    .ZValid(z_valid), .ZReady(z_ready), .Z(z), .FirstIdx(first_idx)
  );

  seq_red_or #(.width(8), .beats(1)) dut1 (
    .CLK(clk), .RSTn(rst_n), .Flush(1'b0),
    .AValid(a_valid1), .AReady(a_ready1), .A(a1),
    .ZValid(z_valid1), .ZReady(z_ready1), .Z(z1), .FirstIdx(first_idx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one beat and wait (bounded) until it is accepted; AValid stays high.
  task automatic send(input logic [7:0] val);
    int waited = 0;
    a_valid = 1'b1;
    a       = val;
    #1;
    while (!a_ready && waited < 20) begin
      step();
      waited++;
      #1;
    end
    if (!a_ready) check("send_timeout", 32'(a_ready), 32'd1);
    step();
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send(b0);
    send(b1);
    send(b2);
    send(b3);
    a_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic v, input logic zz, input logic [1:0] fi);
    check({tag, "_zvalid"}, 32'(z_valid), 32'(v));
    check({tag, "_z"}, 32'(z), 32'(zz));
    check({tag, "_idx"}, 32'(first_idx), 32'(fi));
  endtask

  logic [7:0] b2b [8];

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    a_valid  = 1'b0;
    a        = '0;
    z_ready  = 1'b1;
    a_valid1 = 1'b0;
    a1       = '0;
    z_ready1 = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1. Reset mid-frame, then an all-zero frame must not see the old 0x10.
    send(8'h00);
    send(8'h10);
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_result("rst_async", 1'b0, 1'b0, 2'd0);
    check("rst_aready", 32'(a_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check_result("rst_rel", 1'b0, 1'b0, 2'd0);
    send_frame(8'h00, 8'h00, 8'h00, 8'h00);
    check_result("rst_noleak", 1'b1, 1'b0, 2'd0);
    step();
    check("rst_consumed", 32'(z_valid), 32'd0);

    // 2. Basic frames with ZReady held high.
    send_frame(8'h00, 8'h00, 8'h80, 8'h01);
    check_result("basic_idx2", 1'b1, 1'b1, 2'd2);
    send_frame(8'h00, 8'h00, 8'h00, 8'h00);
    check_result("basic_zero", 1'b1, 1'b0, 2'd0);
    send_frame(8'h00, 8'h00, 8'h00, 8'h04);
    check_result("basic_idx3", 1'b1, 1'b1, 2'd3);
    step();

    // 3. Back-to-back frames: no AReady stall, results after beats 4 and 8.
    b2b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1;
      a       = b2b[i];
      #1;
      check($sformatf("b2b_aready%0d", i), 32'(a_ready), 32'd1);
      step();
      if (i == 3) check_result("b2b_first", 1'b1, 1'b1, 2'd0);
      if (i == 4) check("b2b_gap", 32'(z_valid), 32'd0);
    end
    a_valid = 1'b0;
    check_result("b2b_second", 1'b1, 1'b1, 2'd1);
    step();

    // 4. Backpressure: last beat of the second frame stalls while result held.
    z_ready = 1'b0;
    send_frame(8'h00, 8'h40, 8'h00, 8'h00);
    check_result("bp_first", 1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a       = (i == 2) ? 8'h02 : 8'h00;
      #1;
      check($sformatf("bp_aready%0d", i), 32'(a_ready), 32'd1);
      step();
    end
    a = 8'h00;
    #1;
    check("bp_stall", 32'(a_ready), 32'd0);
    step();
    step();
    check_result("bp_hold", 1'b1, 1'b1, 2'd1);
    z_ready = 1'b1;
    #1;
    check("bp_release", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check_result("bp_second", 1'b1, 1'b1, 2'd2);
    step();
    check("bp_drained", 32'(z_valid), 32'd0);

    // 5. Flush discards the partial frame and its same-cycle beat.
    send(8'h00);
    send(8'h02);
    a     = 8'hFF;
    flush = 1'b1;
    step();
    flush   = 1'b0;
    a_valid = 1'b0;
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("flush_no_early", 32'(z_valid), 32'd0);
    send(8'h00);
    a_valid = 1'b0;
    check_result("flush_clean", 1'b1, 1'b0, 2'd0);
    step();
    z_ready = 1'b0;
    send_frame(8'h00, 8'h00, 8'h00, 8'h08);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_result("flush_held", 1'b1, 1'b1, 2'd3);
    z_ready = 1'b1;
    step();
    check("flush_consumed", 32'(z_valid), 32'd0);

    // 6. Single-beat frames: one result per cycle, index always 0.
    a_valid1 = 1'b1;
    a1       = 8'h00;
    step();
    check("sb_v0", 32'(z_valid1), 32'd1);
    check("sb_z0", 32'(z1), 32'd0);
    check("sb_i0", 32'(first_idx1), 32'd0);
    a1 = 8'h08;
    #1;
    check("sb_aready", 32'(a_ready1), 32'd1);
    step();
    a_valid1 = 1'b0;
    check("sb_v1", 32'(z_valid1), 32'd1);
    check("sb_z1", 32'(z1), 32'd1);
    check("sb_i1", 32'(first_idx1), 32'd0);
    step();
    check("sb_drained", 32'(z_valid1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
